// File: rtl/draw_engine.sv
// draw_engine: queued RECT/CLEAR fill engine that turns each command into
// row-bounded write bursts for a framebuffer memory controller.
module draw_engine #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int MAX_BURST  = 256,
    parameter int BASE_ADDR  = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  command,
    input  logic [255:0]                data,
    input  logic                        commit,
    output logic                        ack,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        write_burst_req,
    output logic [21:0]                 addr,
    output logic [9:0]                  write_burst_len,
    output logic [15:0]                 rgb,
    input  logic                        write_burst_data_req,
    input  logic                        write_burst_data_finish,
    output logic                        done,
    output logic                        error
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [10:0]   SW         = 11'(SCREEN_W);
    localparam logic [10:0]   SH         = 11'(SCREEN_H);
    localparam logic [10:0]   MB         = 11'(MAX_BURST);
    localparam logic [7:0]    OP_RECT    = 8'h01;
    localparam logic [7:0]    OP_CLEAR   = 8'h02;

    typedef enum logic [2:0] {IDLE, FETCH, SETUP, REQ, DATA, NEXT, DONE} state_t;
    state_t state, next_state;

    logic [7:0]    op_mem  [FIFO_DEPTH];
    logic [55:0]   arg_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          push, pop;

    logic [7:0]  op_reg;
    logic [9:0]  fx, fy, fw, fh;
    logic [15:0] color;
    logic [10:0] x_start, x_end, y_end, col, row;
    logic        err_flag;

    logic [10:0] eff_x, eff_y, eff_w, eff_h, room_w, room_h, clip_w, clip_h;
    logic        setup_err;
    logic [10:0] remain, blen, col_adv, row_inc;
    logic        row_done, last_row;
    logic [21:0] burst_addr;
    logic        unused_bits;

    // Only the low 56 data bits carry fields; the remainder is deliberately dropped.
    assign unused_bits = ^{data[255:56], blen[10]};

    // An offer is accepted whenever the registered level shows a free slot.
    assign ack        = rst_n & commit & (level != FULL_LEVEL);
    assign push       = ack;
    assign pop        = (state == FETCH);
    assign fifo_level = level;

    // Queue pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      level <= level + LW'(1);
            else if (!push && pop) level <= level - LW'(1);
        end
    end

    // Queue storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]  <= command;
            arg_mem[wr_ptr] <= data[55:0];
        end
    end

    // Resolve the drawing window for the fetched command and clip it to the screen.
    always_comb begin
        eff_x = {1'b0, fx};
        eff_y = {1'b0, fy};
        eff_w = {1'b0, fw};
        eff_h = {1'b0, fh};
        if (op_reg == OP_CLEAR) begin
            eff_x = '0;
            eff_y = '0;
            eff_w = SW;
            eff_h = SH;
        end
        room_w    = (eff_x < SW) ? (SW - eff_x) : '0;
        room_h    = (eff_y < SH) ? (SH - eff_y) : '0;
        clip_w    = (eff_w < room_w) ? eff_w : room_w;
        clip_h    = (eff_h < room_h) ? eff_h : room_h;
        setup_err = ((op_reg != OP_RECT) && (op_reg != OP_CLEAR)) ||
                    (clip_w == '0) || (clip_h == '0);
    end

    // Burst sizing: never past the row end, never more than MAX_BURST pixels.
    assign remain     = x_end - col;
    assign blen       = (remain > MB) ? MB : remain;
    assign col_adv    = col + blen;
    assign row_inc    = row + 11'd1;
    assign row_done   = (col_adv >= x_end);
    assign last_row   = (row_inc >= y_end);
    assign burst_addr = 22'(BASE_ADDR) + 22'(row) * 22'(SCREEN_W) + 22'(col);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state and Moore outputs; IDLE also looks at this cycle's push so a
    // command into an empty queue starts fetching right after it is stored.
    always_comb begin
        next_state      = state;
        write_burst_req = 1'b0;
        addr            = '0;
        write_burst_len = '0;
        rgb             = '0;
        done            = 1'b0;
        error           = 1'b0;
        busy            = (level != '0) || (state != IDLE);
        case (state)
            IDLE:  if ((level != '0) || push) next_state = FETCH;
            FETCH: next_state = SETUP;
            SETUP: next_state = setup_err ? DONE : REQ;
            REQ: begin
                write_burst_req = 1'b1;
                addr            = burst_addr;
                write_burst_len = blen[9:0];
                if (write_burst_data_req) next_state = DATA;
            end
            DATA: begin
                addr            = burst_addr;
                write_burst_len = blen[9:0];
                rgb             = color;
                if (write_burst_data_finish) next_state = NEXT;
            end
            NEXT:  next_state = (row_done && last_row) ? DONE : REQ;
            DONE: begin
                done       = 1'b1;
                error      = err_flag;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Working registers: load the queue head, set up the window, walk rows and bursts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg   <= '0;
            fx       <= '0;
            fy       <= '0;
            fw       <= '0;
            fh       <= '0;
            color    <= '0;
            x_start  <= '0;
            x_end    <= '0;
            y_end    <= '0;
            col      <= '0;
            row      <= '0;
            err_flag <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    op_reg <= op_mem[rd_ptr];
                    fx     <= arg_mem[rd_ptr][9:0];
                    fy     <= arg_mem[rd_ptr][19:10];
                    fw     <= arg_mem[rd_ptr][29:20];
                    fh     <= arg_mem[rd_ptr][39:30];
                    color  <= arg_mem[rd_ptr][55:40];
                end
                SETUP: begin
                    x_start  <= eff_x;
                    col      <= eff_x;
                    row      <= eff_y;
                    x_end    <= eff_x + clip_w;
                    y_end    <= eff_y + clip_h;
                    err_flag <= setup_err;
                end
                NEXT: begin
                    if (row_done) begin
                        col <= x_start;
                        row <= row_inc;
                    end else begin
                        col <= col_adv;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_draw_engine.sv
// tb_draw_engine: directed vectors for draw_engine with a simple memory
// controller model that logs every burst it accepts.
module tb_draw_engine;
    localparam logic [7:0] RECT  = 8'h01;
    localparam logic [7:0] CLEAR = 8'h02;

    logic         clk;
    logic         rst_n;
    logic [7:0]   command;
    logic [255:0] data;
    logic         commit;
    logic         ack;
    logic         busy;
    logic [2:0]   fifoLevel;
    logic         writeBurstReq;
    logic [21:0]  addr;
    logic [9:0]   writeBurstLen;
    logic [15:0]  rgb;
    logic         writeBurstDataReq;
    logic         writeBurstDataFinish;
    logic         done;
    logic         error;

    int testsRun    = 0;
    int testsFailed = 0;
    int doneCount   = 0;
    int errorCount  = 0;
    int errorAlone  = 0;
    bit ctrlEnable;
    int dataWait;
    int burstAddr[$];
    int burstLen[$];
    int burstRgb[$];

    draw_engine dut (
        .clk(clk),
        .rst_n(rst_n),
        .command(command),
        .data(data),
        .commit(commit),
        .ack(ack),
        .busy(busy),
        .fifo_level(fifoLevel),
        .write_burst_req(writeBurstReq),
        .addr(addr),
        .write_burst_len(writeBurstLen),
        .rgb(rgb),
        .write_burst_data_req(writeBurstDataReq),
        .write_burst_data_finish(writeBurstDataFinish),
        .done(done),
        .error(error)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completion and error pulses.
    always @(negedge clk) begin
        if (done) doneCount++;
        if (error) errorCount++;
        if (error && !done) errorAlone++;
    end

    // Memory controller model: accept a request, capture its pixel, finish later.
    initial begin
        int phase;
        int holdCount;
        phase = 0;
        holdCount = 0;
        writeBurstDataReq = 1'b0;
        writeBurstDataFinish = 1'b0;
        forever begin
            @(negedge clk);
            writeBurstDataReq = 1'b0;
            writeBurstDataFinish = 1'b0;
            if (!rst_n) begin
                phase = 0;
            end else if (phase == 0) begin
                if (writeBurstReq && ctrlEnable) begin
                    writeBurstDataReq = 1'b1;
                    burstAddr.push_back(int'(addr));
                    burstLen.push_back(int'(writeBurstLen));
                    phase = 1;
                end
            end else if (phase == 1) begin
                burstRgb.push_back(int'(rgb));
                holdCount = dataWait;
                phase = 2;
            end else begin
                if (holdCount > 0) begin
                    holdCount--;
                end else begin
                    writeBurstDataFinish = 1'b1;
                    phase = 0;
                end
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [255:0] mk(input int x, input int y, input int w,
                                        input int h, input logic [15:0] c);
        logic [255:0] d;
        d = '0;
        d[9:0]   = 10'(x);
        d[19:10] = 10'(y);
        d[29:20] = 10'(w);
        d[39:30] = 10'(h);
        d[55:40] = c;
        return d;
    endfunction

    task automatic checkOutput(input string tag, input int got, input int expected);
        testsRun++;
        if (got !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, expected);
        end
    endtask

    // Offer one command and hold it until accepted; returns at posedge+2.
    task automatic applyStimulus(input logic [7:0] cmd, input logic [255:0] d, output bit got);
        command = cmd;
        data = d;
        commit = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = ack;
            @(posedge clk);
            #2;
        end
        commit = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int target);
        int cycles;
        cycles = 0;
        while (doneCount < target && cycles < 5000) begin
            @(posedge clk);
            cycles++;
        end
        checkOutput({tag, "_done_reached"}, int'(doneCount >= target), 1);
        repeat (20) @(posedge clk);
        #2;
        checkOutput({tag, "_done_count"}, doneCount, target);
    endtask

    task automatic checkBurst(input string tag, input int idx, input int expAddr,
                              input int expLen, input int expRgb);
        checkOutput({tag, "_present"}, int'(idx < burstAddr.size()), 1);
        if (idx < burstAddr.size() && idx < burstRgb.size()) begin
            checkOutput({tag, "_addr"}, burstAddr[idx], expAddr);
            checkOutput({tag, "_len"}, burstLen[idx], expLen);
            checkOutput({tag, "_rgb"}, burstRgb[idx], expRgb);
        end
    endtask

    task automatic clearLog();
        burstAddr.delete();
        burstLen.delete();
        burstRgb.delete();
    endtask

    initial begin
        bit got;
        int base;
        int errBase;
        int acks;
        int peak;
        int fullAck;
        int k;
        int cycles;

        rst_n = 1'b0;
        commit = 1'b1;
        command = RECT;
        data = mk(1, 1, 1, 1, 16'h1234);
        ctrlEnable = 1'b1;
        dataWait = 0;

        // Reset state, with an offer pending to show ack is held low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ack", ack, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_level", fifoLevel, 0);
        checkOutput("rst_req", writeBurstReq, 0);
        checkOutput("rst_addr", addr, 0);
        checkOutput("rst_len", writeBurstLen, 0);
        checkOutput("rst_rgb", rgb, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        @(posedge clk);
        #2;
        commit = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Two-row rectangle and request latency from an empty, idle engine.
        clearLog();
        base = doneCount;
        errBase = errorCount;
        applyStimulus(RECT, mk(10, 20, 100, 2, 16'hF800), got);
        checkOutput("r1_ack", got, 1);
        @(negedge clk);
        checkOutput("r1_busy", busy, 1);
        @(negedge clk);
        checkOutput("r1_req_before", writeBurstReq, 0);
        @(negedge clk);
        checkOutput("r1_req_latency", writeBurstReq, 1);
        waitDone("r1", base + 1);
        checkOutput("r1_bursts", burstAddr.size(), 2);
        checkBurst("r1_b0", 0, 12810, 100, 16'hF800);
        checkBurst("r1_b1", 1, 13450, 100, 16'hF800);
        checkOutput("r1_error", errorCount, errBase);
        checkOutput("r1_idle", busy, 0);

        // A row longer than MAX_BURST splits into 256/256/88.
        clearLog();
        base = doneCount;
        applyStimulus(RECT, mk(0, 0, 600, 1, 16'h001F), got);
        waitDone("r2", base + 1);
        checkOutput("r2_bursts", burstAddr.size(), 3);
        checkBurst("r2_b0", 0, 0, 256, 16'h001F);
        checkBurst("r2_b1", 1, 256, 256, 16'h001F);
        checkBurst("r2_b2", 2, 512, 88, 16'h001F);

        // Clipping at the bottom-right corner: 40x10.
        clearLog();
        base = doneCount;
        applyStimulus(RECT, mk(600, 470, 100, 50, 16'h07E0), got);
        waitDone("r3", base + 1);
        checkOutput("r3_bursts", burstAddr.size(), 10);
        checkBurst("r3_first", 0, 301400, 40, 16'h07E0);
        checkBurst("r3_last", 9, 301400 + 9 * 640, 40, 16'h07E0);
        for (int i = 0; i < 10 && i < burstLen.size(); i++)
            checkOutput($sformatf("r3_len%0d", i), burstLen[i], 40);

        // Rejected commands: off-screen x and an unknown opcode.
        clearLog();
        base = doneCount;
        errBase = errorCount;
        applyStimulus(RECT, mk(700, 0, 10, 10, 16'hFFFF), got);
        waitDone("e1", base + 1);
        checkOutput("e1_error", errorCount, errBase + 1);
        applyStimulus(8'h07, mk(0, 0, 10, 10, 16'hFFFF), got);
        waitDone("e2", base + 2);
        checkOutput("e2_error", errorCount, errBase + 2);
        checkOutput("e_no_bursts", burstAddr.size(), 0);
        checkOutput("e_error_with_done", errorAlone, 0);

        // Fill the queue while the controller stalls the engine.
        clearLog();
        base = doneCount;
        ctrlEnable = 1'b0;
        applyStimulus(RECT, mk(0, 100, 8, 1, 16'h00AA), got);
        repeat (6) @(posedge clk);
        #2;
        checkOutput("f_stalled_req", writeBurstReq, 1);
        checkOutput("f_level_empty", fifoLevel, 0);
        acks = 0;
        peak = 0;
        fullAck = 0;
        k = 0;
        command = RECT;
        data = mk(0, 0, 8, 1, 16'h0100);
        commit = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (int'(fifoLevel) > peak) peak = int'(fifoLevel);
            if (fifoLevel == 3'd4 && ack) fullAck++;
            if (ack) acks++;
            got = ack;
            @(posedge clk);
            #2;
            if (got) begin
                k++;
                if (k < 6) data = mk(0, k, 8, 1, 16'(16'h0100 + k));
                else commit = 1'b0;
            end
        end
        @(negedge clk);
        checkOutput("f_acks", acks, 4);
        checkOutput("f_peak", peak, 4);
        checkOutput("f_ack_while_full", fullAck, 0);
        checkOutput("f_ack_now", ack, 0);
        ctrlEnable = 1'b1;
        @(posedge clk);
        #2;
        for (int c = 0; c < 400 && k < 6; c++) begin
            @(negedge clk);
            got = ack;
            @(posedge clk);
            #2;
            if (got) begin
                k++;
                if (k < 6) data = mk(0, k, 8, 1, 16'(16'h0100 + k));
                else commit = 1'b0;
            end
        end
        commit = 1'b0;
        checkOutput("f_all_accepted", k, 6);
        waitDone("f", base + 7);
        checkOutput("f_bursts", burstAddr.size(), 7);
        checkBurst("f_b0", 0, 100 * 640, 8, 16'h00AA);
        for (int i = 0; i < 6; i++)
            checkBurst($sformatf("f_order%0d", i), i + 1, i * 640, 8, 16'h0100 + i);

        // CLEAR interrupted by reset mid-burst, with a second command queued.
        clearLog();
        dataWait = 30;
        applyStimulus(CLEAR, mk(5, 5, 5, 5, 16'h07E0), got);
        applyStimulus(RECT, mk(0, 200, 8, 1, 16'h0F0F), got);
        cycles = 0;
        while (burstRgb.size() < 1 && cycles < 200) begin
            @(posedge clk);
            cycles++;
        end
        #2;
        @(negedge clk);
        checkOutput("c_in_data_rgb", rgb, 16'h07E0);
        checkOutput("c_queued", fifoLevel, 1);
        checkBurst("c_b0", 0, 0, 256, 16'h07E0);
        base = doneCount;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        commit = 1'b1;
        @(negedge clk);
        checkOutput("c_rst_ack", ack, 0);
        checkOutput("c_rst_busy", busy, 0);
        checkOutput("c_rst_level", fifoLevel, 0);
        checkOutput("c_rst_req", writeBurstReq, 0);
        checkOutput("c_rst_addr", addr, 0);
        checkOutput("c_rst_len", writeBurstLen, 0);
        checkOutput("c_rst_rgb", rgb, 0);
        checkOutput("c_rst_done", done, 0);
        checkOutput("c_rst_error", error, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        commit = 1'b0;
        dataWait = 0;
        clearLog();
        repeat (50) @(posedge clk);
        #2;
        checkOutput("c_no_replay", burstAddr.size(), 0);
        checkOutput("c_no_done", doneCount, base);
        applyStimulus(RECT, mk(5, 5, 10, 1, 16'h001F), got);
        waitDone("c_after", base + 1);
        checkOutput("c_after_bursts", burstAddr.size(), 1);
        checkBurst("c_after_b0", 0, 3205, 10, 16'h001F);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/draw_engine.md
DRAW_ENGINE -- requirements
Module: draw_engine

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4 (a power of 2, ≥2), giving the command queue depth.
REQ-002 SHALL have parameter SCREEN_W, default 640, giving the framebuffer width in pixels.
REQ-003 SHALL have parameter SCREEN_H, default 480, giving the framebuffer height in pixels.
REQ-004 SHALL have parameter MAX_BURST, default 256 (≤1023), giving the maximum pixels per write burst.
REQ-005 SHALL have parameter BASE_ADDR, default 0, giving the framebuffer base word address.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port command, input, 8 bits: opcode, where 8'h01 is RECT and 8'h02 is CLEAR.
REQ-009 SHALL have port data, input, 256 bits: x[9:0], y[19:10], width[29:20], height[39:30], color[55:40].
REQ-010 SHALL have port commit, input, 1 bit: the producer offers command/data this cycle.
REQ-011 SHALL have port ack, output, 1 bit: the offer is accepted this cycle.
REQ-012 SHALL have port busy, output, 1 bit: the queue is non-empty or the engine is not IDLE.
REQ-013 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: number of queued commands.
REQ-014 SHALL have port write_burst_req, output, 1 bit: burst request to the memory controller.
REQ-015 SHALL have port addr, output, 22 bits: burst start word address.
REQ-016 SHALL have port write_burst_len, output, 10 bits: burst length in pixels.
REQ-017 SHALL have port rgb, output, 16 bits: pixel data.
REQ-018 SHALL have port write_burst_data_req, input, 1 bit: the controller consumes rgb this cycle.
REQ-019 SHALL have port write_burst_data_finish, input, 1 bit: the controller signals the burst is complete.
REQ-020 SHALL have port done, output, 1 bit: one-cycle pulse when a command completes.
REQ-021 SHALL have port error, output, 1 bit: one-cycle pulse, coincident with done, when a command is rejected.

Function
REQ-022 SHALL drive ack = commit & (fifo_level != FIFO_DEPTH), using the registered level; a pop in the same cycle does not free a slot for that cycle's push.
REQ-023 SHALL write command and data into the FIFO on the ack cycle; an offer that is not acked is not stored, and the producer holds it.
REQ-024 SHALL implement the FIFO with wrap-around read/write pointers; a simultaneous push and pop leaves fifo_level unchanged.
REQ-025 SHALL implement the states IDLE, FETCH, SETUP, REQ, DATA, NEXT and DONE.
REQ-026 SHALL, in IDLE, go to FETCH when the FIFO is non-empty; otherwise remain in IDLE.
REQ-027 SHALL, in FETCH, pop the FIFO head into working registers and go to SETUP.
REQ-028 SHALL, in SETUP for RECT: clip width to min(width, SCREEN_W-x) and height to min(height, SCREEN_H-y).
REQ-029 SHALL, in SETUP for CLEAR: use x=0, y=0, width=SCREEN_W, height=SCREEN_H, and ignore the x, y, width and height fields.
REQ-030 SHALL, in SETUP, go to DONE with error when x ≥ SCREEN_W, y ≥ SCREEN_H, the clipped width is 0, the clipped height is 0, or the opcode is unknown; otherwise go to REQ.
REQ-031 SHALL, in REQ: hold write_burst_req=1, addr = BASE_ADDR + row*SCREEN_W + col, and write_burst_len = min(MAX_BURST, remaining pixels in the row) stable until write_burst_data_req is seen, then go to DATA with write_burst_req=0 from the next cycle.
REQ-032 SHALL, in DATA, hold rgb = color and go to NEXT on write_burst_data_finish.
REQ-033 SHALL, in NEXT, advance col by write_burst_len; when the row is exhausted, reset col to x and increment row; go to DONE after the last row, otherwise go to REQ.
REQ-034 SHALL, in DONE, pulse done for one cycle and return to IDLE.
REQ-035 SHALL split each row into ceil(w/MAX_BURST) bursts and never issue a burst that crosses a row.
REQ-036 SHALL compute addresses modulo 2^22.
REQ-037 SHALL assert write_burst_req exactly 3 cycles after an ack into an empty FIFO with the engine in IDLE.
REQ-038 SHALL accept commits while drawing, with no bubble beyond FETCH/SETUP between queued commands.
REQ-039 SHALL ignore write_burst_data_req outside REQ/DATA and write_burst_data_finish outside DATA.

Reset
REQ-040 SHALL, while rst_n=0 at any time, including mid-burst: empty the FIFO, enter IDLE, and drive ack, busy, fifo_level, write_burst_req, addr, write_burst_len, rgb, done and error to 0.
REQ-041 SHALL issue no partial or resumed burst after reset release; dropped commands are not replayed.

Verification
REQ-042 SHALL cover: RECT x=10, y=20, w=100, h=2, color=16'hF800 -> bursts at addr 12810 and 13450, each len 100, rgb=F800; one done pulse; error=0.
REQ-043 SHALL cover: RECT x=0, y=0, w=600, h=1 with MAX_BURST=256 -> bursts len 256, 256, 88 at addr 0, 256, 512.
REQ-044 SHALL cover: RECT x=600, y=470, w=100, h=50 -> clipped to 40x10; 10 bursts of len 40; the first at addr 301400.
REQ-045 SHALL cover: RECT x=700, plus opcode 8'h07 -> each yields done together with error, and no write_burst_req.
REQ-046 SHALL cover: 6 back-to-back commits with FIFO_DEPTH=4 while the engine is stalled -> 4 acks, ack=0 while full, and fifo_level peaking at 4; the remainder are accepted after pops; execution is in FIFO order.
REQ-047 SHALL cover: CLEAR, then rst_n low for 1 cycle mid-DATA -> all outputs 0 and fifo_level 0; a following RECT executes normally.
